add_comp_sel_n: RTL and testbench

ADD_COMP_SEL_N -- requirements
Module: add_comp_sel_n

---
 rtl/acs_pkg.sv | 30 +++
 rtl/acs_cell.sv | 26 ++
 rtl/add_comp_sel_n.sv | 156 +++++++++++++++
 tb/tb_add_comp_sel_n.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/acs_pkg.sv
// Shared types and trellis helpers for the add-compare-select datapath.
package acs_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } acs_state_e;

  // Non-zero states start at 2^(PM_W - INIT_PM_SHIFT) so the zero state dominates.
  localparam int unsigned INIT_PM_SHIFT = 2;

  function automatic int unsigned init_metric(input int unsigned pm_w);
    return 32'(1) << (pm_w - INIT_PM_SHIFT);
  endfunction

  // Predecessor of next-state ns: {ns[m-2:0], odd}.
  function automatic int unsigned pred_idx(input int unsigned ns, input int unsigned m,
                                           input logic odd);
    int unsigned mask;
    mask = (32'(1) << m) - 32'(1);
    return ((ns << 1) & mask) | 32'(odd);
  endfunction

  // Coded pair {c0,c1} for register contents r = {u, s}.
  function automatic logic [1:0] branch_label(input logic [7:0] r, input logic [7:0] g0,
                                              input logic [7:0] g1);
    return {^(r & g0), ^(r & g1)};
  endfunction

endpackage

// File: rtl/acs_cell.sv
// One add-compare-select butterfly half: two candidate sums, pick the smaller, tie -> even.
module acs_cell
  import acs_pkg::*;
#(
  parameter int unsigned BM_W = 2,
  parameter int unsigned PM_W = 6
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [BM_W-1:0] bm0_i,
  input  logic [BM_W-1:0] bm1_i,
  output logic [PM_W:0]   metric_c_o,
  output logic            dec_c_o
);

  localparam int unsigned SW = PM_W + 1;

  logic [PM_W:0] cand0;
  logic [PM_W:0] cand1;

  assign cand0      = SW'(pm0_i) + SW'(bm0_i);
  assign cand1      = SW'(pm1_i) + SW'(bm1_i);
  assign dec_c_o    = (cand1 < cand0);
  assign metric_c_o = dec_c_o ? cand1 : cand0;

endmodule

// File: rtl/add_comp_sel_n.sv
// Viterbi add-compare-select array with metric normalisation and best-state search.
// Optional feature: define ACS_NORM_EN for MSB normalisation; otherwise metrics saturate.
module add_comp_sel_n
  import acs_pkg::*;
#(
  parameter int unsigned K    = 3,
  parameter int unsigned G0   = 7,
  parameter int unsigned G1   = 5,
  parameter int unsigned BM_W = 2,
  parameter int unsigned PM_W = 6,
  localparam int unsigned NS  = 1 << (K - 1),
  localparam int unsigned M   = K - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en_add,
  input  logic [4*BM_W-1:0] bm,
  output logic [NS-1:0]     dec_out,
  output logic              dec_valid,
  output logic [M-1:0]      best_state,
  output logic [PM_W-1:0]   best_pm,
  output logic              norm_flag
);

  acs_state_e      state_q, state_d;
  logic [PM_W-1:0] pm_q [NS];
  logic [PM_W-1:0] pm_d [NS];
  logic [PM_W-1:0] pm_new [NS];
  logic [PM_W:0]   metric_c [NS];
  logic [NS-1:0]   dec_c;
  logic [NS-1:0]   dec_q, dec_d;
  logic            valid_q, valid_d;
  logic [M-1:0]    best_state_q, best_state_d;
  logic [PM_W-1:0] best_pm_q, best_pm_d;
  logic            norm_q, norm_d;
  logic            norm_hit;
  logic [M-1:0]    scan_idx;
  logic [PM_W-1:0] scan_val;

  // One ACS cell per next-state; predecessor wiring and branch labels are elaboration constants.
  for (genvar i = 0; i < NS; i++) begin : g_cell
    localparam int unsigned U  = (i >= NS / 2) ? 1 : 0;
    localparam int unsigned P0 = pred_idx(i, M, 1'b0);
    localparam int unsigned P1 = pred_idx(i, M, 1'b1);
    localparam logic [1:0]  L0 = branch_label(8'((U << M) | P0), 8'(G0), 8'(G1));
    localparam logic [1:0]  L1 = branch_label(8'((U << M) | P1), 8'(G0), 8'(G1));

    acs_cell #(
      .BM_W(BM_W),
      .PM_W(PM_W)
    ) u_cell (
      .pm0_i     (pm_q[P0]),
      .pm1_i     (pm_q[P1]),
      .bm0_i     (bm[32'(L0) * BM_W +: BM_W]),
      .bm1_i     (bm[32'(L1) * BM_W +: BM_W]),
      .metric_c_o(metric_c[i]),
      .dec_c_o   (dec_c[i])
    );
  end

  // Bound the raw ACS sums back into PM_W bits.
  always_comb begin
`ifdef ACS_NORM_EN
    logic all_msb;
    all_msb = 1'b1;
    for (int unsigned s = 0; s < NS; s++) begin
      pm_new[s] = metric_c[s][PM_W-1:0];
      all_msb   = all_msb & metric_c[s][PM_W-1];
    end
    if (all_msb) begin
      for (int unsigned s = 0; s < NS; s++) begin
        pm_new[s][PM_W-1] = 1'b0;
      end
    end
    norm_hit = all_msb;
`else
    for (int unsigned s = 0; s < NS; s++) begin
      pm_new[s] = metric_c[s][PM_W] ? '1 : metric_c[s][PM_W-1:0];
    end
    norm_hit = 1'b0;
`endif
  end

  // Smallest new metric; strict compare keeps the lowest index on ties.
  always_comb begin
    scan_idx = '0;
    scan_val = pm_new[0];
    for (int unsigned s = 1; s < NS; s++) begin
      if (pm_new[s] < scan_val) begin
        scan_val = pm_new[s];
        scan_idx = M'(s);
      end
    end
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d      = state_q;
    valid_d      = 1'b0;
    norm_d       = 1'b0;
    dec_d        = dec_q;
    best_state_d = best_state_q;
    best_pm_d    = best_pm_q;
    for (int unsigned s = 0; s < NS; s++) begin
      pm_d[s] = pm_q[s];
    end

    if (start) begin
      state_d = ST_RUN;
      for (int unsigned s = 0; s < NS; s++) begin
        pm_d[s] = (s == 0) ? '0 : PM_W'(init_metric(PM_W));
      end
    end else if (state_q == ST_RUN && en_add) begin
      valid_d      = 1'b1;
      norm_d       = norm_hit;
      dec_d        = dec_c;
      best_state_d = scan_idx;
      best_pm_d    = scan_val;
      for (int unsigned s = 0; s < NS; s++) begin
        pm_d[s] = pm_new[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      valid_q      <= 1'b0;
      norm_q       <= 1'b0;
      dec_q        <= '0;
      best_state_q <= '0;
      best_pm_q    <= '0;
      for (int unsigned s = 0; s < NS; s++) begin
        pm_q[s] <= '0;
      end
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      norm_q       <= norm_d;
      dec_q        <= dec_d;
      best_state_q <= best_state_d;
      best_pm_q    <= best_pm_d;
      for (int unsigned s = 0; s < NS; s++) begin
        pm_q[s] <= pm_d[s];
      end
    end
  end

  assign dec_out    = dec_q;
  assign dec_valid  = valid_q;
  assign best_state = best_state_q;
  assign best_pm    = best_pm_q;
  assign norm_flag  = norm_q;

endmodule

// File: tb/tb_add_comp_sel_n.sv
// Directed bench for add_comp_sel_n (K=3, G0=7, G1=5, BM_W=2, PM_W=6).
module tb_add_comp_sel_n;

  localparam int unsigned BM_W = 2;
  localparam int unsigned PM_W = 6;
  localparam int unsigned NS   = 4;
  localparam int unsigned M    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              en_add;
  logic [4*BM_W-1:0] bm;
  logic [NS-1:0]     dec_out;
  logic              dec_valid;
  logic [M-1:0]      best_state;
  logic [PM_W-1:0]   best_pm;
  logic              norm_flag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  add_comp_sel_n #(
    .K(3), .G0(7), .G1(5), .BM_W(BM_W), .PM_W(PM_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .en_add    (en_add),
    .bm        (bm),
    .dec_out   (dec_out),
    .dec_valid (dec_valid),
    .best_state(best_state),
    .best_pm   (best_pm),
    .norm_flag (norm_flag)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic       en;
    logic [7:0] bm;
    logic       valid;
    logic [3:0] dec;
    logic [1:0] bs;
    logic [5:0] bpm;
    logic [5:0] pm [4];
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic e, input logic [7:0] b,
                              input logic v, input logic [3:0] d, input logic [1:0] bs,
                              input logic [5:0] bp, input logic [5:0] p0, input logic [5:0] p1,
                              input logic [5:0] p2, input logic [5:0] p3);
    vec_t t;
    t.rst = r; t.start = s; t.en = e; t.bm = b;
    t.valid = v; t.dec = d; t.bs = bs; t.bpm = bp;
    t.pm[0] = p0; t.pm[1] = p1; t.pm[2] = p2; t.pm[3] = p3;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pm(input string tag, input logic [5:0] e0, input logic [5:0] e1,
                          input logic [5:0] e2, input logic [5:0] e3);
    chk({tag, ".pm0"}, 32'(dut.pm_q[0]), 32'(e0));
    chk({tag, ".pm1"}, 32'(dut.pm_q[1]), 32'(e1));
    chk({tag, ".pm2"}, 32'(dut.pm_q[2]), 32'(e2));
    chk({tag, ".pm3"}, 32'(dut.pm_q[3]), 32'(e3));
  endtask

  task automatic drive(input logic r, input logic s, input logic e, input logic [7:0] b);
    rst = r; start = s; en_add = e; bm = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_upd;
    logic [5:0] exp_pm;
    logic       exp_norm;
    string      tag;

    rst = 1'b1; start = 1'b0; en_add = 1'b0; bm = '0;

    // rst start en bm | valid dec bs bpm | pm[0..3]
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'b0000, 0, 0,  0,  0,  0,  0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 1, 8'hFF, 0, 4'b0000, 0, 0,  0,  0,  0,  0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 4'b0000, 0, 0,  0, 16, 16, 16));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 4'b0000, 0, 0,  0, 16,  0, 16));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 4'b0000, 0, 0,  0, 16,  0, 16));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 4'b0000, 0, 0,  0, 16, 16, 16));
    vecs.push_back(mk(0, 0, 1, 8'hA8, 1, 4'b0000, 0, 0,  0, 18,  2, 18));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 4'b0000, 0, 0,  0, 16, 16, 16));
    vecs.push_back(mk(0, 0, 1, 8'hFF, 1, 4'b0000, 0, 3,  3, 19,  3, 19));
    vecs.push_back(mk(0, 0, 1, 8'hFF, 1, 4'b0000, 0, 6,  6,  6,  6,  6));
    vecs.push_back(mk(0, 0, 1, 8'hF3, 1, 4'b0010, 1, 6,  9,  6,  9,  6));
    vecs.push_back(mk(0, 0, 1, 8'h3F, 1, 4'b1011, 0, 6,  6,  9,  9,  9));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 4'b1011, 0, 6,  0, 16, 16, 16));
    vecs.push_back(mk(0, 0, 1, 8'hFF, 1, 4'b0000, 0, 3,  3, 19,  3, 19));
    vecs.push_back(mk(1, 0, 1, 8'hFF, 0, 4'b0000, 0, 0,  0,  0,  0,  0));
    vecs.push_back(mk(0, 0, 1, 8'hFF, 0, 4'b0000, 0, 0,  0,  0,  0,  0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 4'b0000, 0, 0,  0, 16, 16, 16));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 4'b0000, 0, 0,  0, 16,  0, 16));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].en, vecs[i].bm);
      tag = $sformatf("v%0d", i);
      chk({tag, ".valid"}, 32'(dec_valid), 32'(vecs[i].valid));
      chk({tag, ".dec"}, 32'(dec_out), 32'(vecs[i].dec));
      chk({tag, ".best_state"}, 32'(best_state), 32'(vecs[i].bs));
      chk({tag, ".best_pm"}, 32'(best_pm), 32'(vecs[i].bpm));
      chk({tag, ".norm"}, 32'(norm_flag), 32'(0));
      check_pm(tag, vecs[i].pm[0], vecs[i].pm[1], vecs[i].pm[2], vecs[i].pm[3]);
    end

    // Long all-3 burst: metrics climb by 3 until normalisation or saturation.
`ifdef ACS_NORM_EN
    n_upd = 11;
`else
    n_upd = 22;
`endif
    drive(0, 1, 0, 8'h00);
    for (int k = 1; k <= n_upd; k++) begin
      drive(0, 0, 1, 8'hFF);
      if (k >= 2) begin
`ifdef ACS_NORM_EN
        exp_pm   = (k == 11) ? 6'd1 : 6'(3 * k);
        exp_norm = (k == 11);
`else
        exp_pm   = (k == 22) ? 6'd63 : 6'(3 * k);
        exp_norm = 1'b0;
`endif
        tag = $sformatf("burst%0d", k);
        chk({tag, ".valid"}, 32'(dec_valid), 32'(1));
        chk({tag, ".norm"}, 32'(norm_flag), 32'(exp_norm));
        chk({tag, ".best_state"}, 32'(best_state), 32'(0));
        chk({tag, ".best_pm"}, 32'(best_pm), 32'(exp_pm));
        check_pm(tag, exp_pm, exp_pm, exp_pm, exp_pm);
      end
    end

    // Idle cycle after the burst: flags drop, results hold.
    drive(0, 0, 0, 8'h00);
    chk("post_burst.valid", 32'(dec_valid), 32'(0));
    chk("post_burst.norm", 32'(norm_flag), 32'(0));
    chk("post_burst.best_pm", 32'(best_pm), 32'(exp_pm));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
